wordcell_array: RTL and testbench

WORDCELL_ARRAY -- requirements
Module: wordcell_array

---
 rtl/wordcell_array.sv | 125 ++++++++++++
 tb/tb_wordcell_array.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wordcell_array.sv
// rtl/wordcell_array.sv - word-addressed storage array with request/response port and sequential clear
// Reads return the pre-edge word one cycle after acceptance; a clear walks one word per cycle.
module wordcell_array #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    input  logic             clr_start,
    output logic             busy,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
    logic             clr_we;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic accept;
    logic addr_ok;
    logic dbg_ok;
    logic wr_en;

    // Address widths can exceed DEPTH when DEPTH is not a power of two.
    assign addr_ok = ({1'b0, req_addr} < DEPTH_W);
    assign dbg_ok  = ({1'b0, dbg_addr} < DEPTH_W);
    assign accept  = req_valid && req_ready;
    assign wr_en   = accept && req_op && addr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        req_ready = 1'b0;
        busy      = 1'b0;
        clr_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                clr_cnt_d = '0;
                if (clr_start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                busy      = 1'b1;
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Requests are never accepted during CLEAR, so clear and write never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_we) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            mem_q[req_addr] <= req_wdata;
        end
    end

    always_comb begin
        rsp_valid_d = accept && !req_op;
        rsp_err_d   = rsp_valid_d && !addr_ok;
        rsp_rdata_d = rsp_rdata_q;
        if (rsp_valid_d) begin
            rsp_rdata_d = addr_ok ? mem_q[req_addr] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign dbg_data  = dbg_ok ? mem_q[dbg_addr] : '0;

endmodule

// File: tb/tb_wordcell_array.sv
// tb/tb_wordcell_array.sv - scoreboard bench for wordcell_array (DEPTH 16 and DEPTH 12 instances)
module tb_wordcell_array;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_valid, a_ready, a_op, a_rsp_valid, a_rsp_err, a_clr, a_busy;
    logic [3:0] a_addr, a_dbg;
    logic [7:0] a_wdata, a_rdata, a_dbg_data;
    logic       b_valid, b_ready, b_op, b_rsp_valid, b_rsp_err, b_clr, b_busy;
    logic [3:0] b_addr, b_dbg;
    logic [7:0] b_wdata, b_rdata, b_dbg_data;

    wordcell_array #(.WIDTH(8), .DEPTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready), .req_op(a_op),
        .req_addr(a_addr), .req_wdata(a_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata),
        .rsp_err(a_rsp_err), .clr_start(a_clr), .busy(a_busy), .dbg_addr(a_dbg), .dbg_data(a_dbg_data)
    );

    wordcell_array #(.WIDTH(8), .DEPTH(12)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready), .req_op(b_op),
        .req_addr(b_addr), .req_wdata(b_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata),
        .rsp_err(b_rsp_err), .clr_start(b_clr), .busy(b_busy), .dbg_addr(b_dbg), .dbg_data(b_dbg_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m16 [16];
    logic [7:0] m12 [12];
    logic [8:0] q16 [$];
    logic [8:0] q12 [$];
    logic [7:0] last16 = '0;
    logic [7:0] last12 = '0;
    logic [8:0] e16, e12;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model update happens at drive time: the request is accepted at the coming edge.
    task automatic drive(input bit sel, input bit op, input int addr, input logic [7:0] data);
        if (!sel) begin
            a_valid = 1'b1; a_op = op; a_addr = 4'(addr); a_wdata = data;
            if (!op) q16.push_back({1'b0, m16[addr]});
            else m16[addr] = data;
        end else begin
            b_valid = 1'b1; b_op = op; b_addr = 4'(addr); b_wdata = data;
            if (!op) q12.push_back((addr >= 12) ? 9'h100 : {1'b0, m12[addr]});
            else if (addr < 12) m12[addr] = data;
        end
    endtask

    task automatic req(input bit sel, input bit op, input int addr, input logic [7:0] data);
        @(negedge clk);
        drive(sel, op, addr, data);
    endtask

    task automatic go_idle();
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0; a_clr = 1'b0; b_clr = 1'b0;
    endtask

    task automatic sweep(input bit sel, input string tag);
        for (int i = 0; i < 16; i++) begin
            if (!sel) begin
                a_dbg = 4'(i); #1;
                chk(tag, a_dbg_data, m16[i]);
            end else begin
                b_dbg = 4'(i); #1;
                chk(tag, b_dbg_data, (i < 12) ? m12[i] : 8'h00);
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (a_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 100), 1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m16[i] = '0;
        for (int i = 0; i < 12; i++) m12[i] = '0;
        last16 = '0;
        last12 = '0;
    endtask

    always @(posedge clk) begin
        #1;
        if (a_rsp_valid) begin
            if (q16.size() == 0) begin
                chk("a_unexpected_rsp", a_rsp_valid, 0);
            end else begin
                e16 = q16.pop_front();
                chk("a_rdata", a_rdata, e16[7:0]);
                chk("a_err", a_rsp_err, e16[8]);
                last16 = e16[7:0];
            end
        end else begin
            chk("a_err_idle", a_rsp_err, 0);
            chk("a_rdata_hold", a_rdata, last16);
        end
        if (b_rsp_valid) begin
            if (q12.size() == 0) begin
                chk("b_unexpected_rsp", b_rsp_valid, 0);
            end else begin
                e12 = q12.pop_front();
                chk("b_rdata", b_rdata, e12[7:0]);
                chk("b_err", b_rsp_err, e12[8]);
                last12 = e12[7:0];
            end
        end else begin
            chk("b_err_idle", b_rsp_err, 0);
            chk("b_rdata_hold", b_rdata, last12);
        end
    end

    initial begin
        int cnt;
        int rdy_bad;
        rst_n = 1'b0;
        a_valid = 0; a_op = 0; a_addr = 0; a_wdata = 0; a_clr = 0; a_dbg = 0;
        b_valid = 0; b_op = 0; b_addr = 0; b_wdata = 0; b_clr = 0; b_dbg = 0;
        model_reset();
        #12;
        chk("rst_ready", a_ready, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_rsp_valid", a_rsp_valid, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_err", a_rsp_err, 0);
        sweep(0, "rst_mem");

        // First request on the first edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 3, 8'hA5);
        req(0, 0, 3, 0);
        req(0, 1, 5, 8'h3C);
        req(0, 0, 5, 0);
        req(0, 0, 3, 0);
        go_idle();
        sweep(0, "basic_mem");

        for (int k = 0; k < 40; k++) begin
            req(0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), 8'($urandom));
        end
        go_idle();
        sweep(0, "rand_mem");

        // Fill, then clear together with a read of word 7.
        for (int i = 0; i < 16; i++) req(0, 1, i, (i == 7) ? 8'h77 : (8'h80 | 8'(i)));
        @(negedge clk);
        drive(0, 0, 7, 0);
        a_clr = 1'b1;
        for (int i = 0; i < 16; i++) m16[i] = '0;
        @(negedge clk);
        a_valid = 1'b0; a_clr = 1'b0;
        cnt = 0; rdy_bad = 0;
        while (a_busy && cnt < 100) begin
            if (a_ready) rdy_bad++;
            cnt++;
            a_clr = (cnt == 4);
            @(negedge clk);
        end
        a_clr = 1'b0;
        chk("clr_busy_cycles", cnt, 16);
        chk("clr_ready_low", rdy_bad, 0);
        chk("clr_ready_after", a_ready, 1);
        sweep(0, "clr_mem");

        // Write concurrent with clear ends up zero.
        req(0, 1, 2, 8'h55);
        @(negedge clk);
        drive(0, 1, 2, 8'h66);
        a_clr = 1'b1;
        for (int i = 0; i < 16; i++) m16[i] = '0;
        go_idle();
        wait_idle("clr_wr_timeout");
        sweep(0, "clr_wr_mem");

        // Reset at CLEAR cycle 6.
        req(0, 1, 9, 8'h99);
        @(negedge clk);
        a_valid = 1'b0; a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_clr_busy", a_busy, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_clr_busy", a_busy, 0);
        chk("rst_clr_ready", a_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", a_busy, 0);
        sweep(0, "rst_clr_mem");

        // Reset while a read response is on the outputs.
        req(0, 1, 4, 8'h44);
        req(0, 0, 4, 0);
        @(posedge clk);
        #3;
        a_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_rsp_valid_drop", a_rsp_valid, 0);
        chk("rst_rsp_rdata", a_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        sweep(0, "rst_rsp_mem");

        // DEPTH 12: out-of-range accesses.
        req(1, 1, 13, 8'hFF);
        req(1, 1, 11, 8'h42);
        req(1, 0, 13, 0);
        req(1, 0, 11, 0);
        req(1, 0, 0, 0);
        go_idle();
        sweep(1, "d12_mem");

        repeat (3) @(negedge clk);
        chk("q16_drained", q16.size(), 0);
        chk("q12_drained", q12.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
